// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL reset sequencer: sequencer states,
// subsystem reset-bit positions and counter sizing helper.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN
    } seq_state_t;

    localparam int unsigned RST_TIMERS = 0;
    localparam int unsigned RST_VIDEO  = 1;
    localparam int unsigned RST_CPU    = 2;

    // Width of a counter that must hold values 0..n-1; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Parameterised-depth flip-flop synchroniser for a single asynchronous input,
// cleared to 0 by the asynchronous active-low reset.
module sync_ff_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies the synchronised PLL lock and releases subsystem resets in order
// (timers/audio/SD, video, CPU); re-asserts all resets and logs lock losses.
module pll_reset_sequencer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned STAGE_GAP     = 16,
    parameter int unsigned NUM_STAGES    = 3,
    parameter int unsigned LOSS_CNT_W    = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pll_locked,
    input  logic                  sw_reset_req,
    input  logic                  clear_status,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

    import pll_rst_pkg::*;

    localparam int unsigned STB_W = cnt_width(STABLE_CYCLES);
    localparam int unsigned GAP_W = cnt_width(STAGE_GAP);
    localparam int unsigned IDX_W = cnt_width(NUM_STAGES);

    logic locked_s;

    sync_ff_chain #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clock (clock),
        .resetn(resetn),
        .d     (pll_locked),
        .q     (locked_s)
    );

    seq_state_t            state_q,      state_d;
    logic [STB_W-1:0]      stable_cnt_q, stable_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q,    gap_cnt_d;
    logic [IDX_W-1:0]      idx_q,        idx_d;
    logic [NUM_STAGES-1:0] rst_out_q,    rst_out_d;
    logic                  ready_q,      ready_d;
    logic                  lock_lost_q,  lock_lost_d;
    logic [LOSS_CNT_W-1:0] loss_cnt_q,   loss_cnt_d;
    logic                  loss;

    always_comb begin
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        idx_d        = idx_q;
        rst_out_d    = rst_out_q;
        ready_d      = ready_q;
        lock_lost_d  = lock_lost_q;
        loss_cnt_d   = loss_cnt_q;
        loss         = 1'b0;

        if (clear_status) begin
            lock_lost_d = 1'b0;
            loss_cnt_d  = '0;
        end

        case (state_q)
            WAIT_LOCK: begin
                rst_out_d = '1;
                ready_d   = 1'b0;
                if (locked_s) begin
                    state_d      = STABLE;
                    stable_cnt_d = '0;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (stable_cnt_q == STB_W'(STABLE_CYCLES - 1)) begin
                    state_d   = RELEASE;
                    gap_cnt_d = '0;
                    idx_d     = IDX_W'(RST_TIMERS);
                end else begin
                    stable_cnt_d = stable_cnt_q + STB_W'(1);
                end
            end
            RELEASE, RUN: begin
                // Lock loss outranks a software request on the same edge.
                if (!locked_s) begin
                    loss = 1'b1;
                end else if (sw_reset_req) begin
                    rst_out_d    = '1;
                    ready_d      = 1'b0;
                    state_d      = STABLE;
                    stable_cnt_d = '0;
                end else if (state_q == RELEASE) begin
                    if (gap_cnt_q == GAP_W'(STAGE_GAP - 1)) begin
                        rst_out_d = rst_out_q & ~(NUM_STAGES'(1) << idx_q);
                        gap_cnt_d = '0;
                        if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
            end
            default: begin
                state_d   = WAIT_LOCK;
                rst_out_d = '1;
                ready_d   = 1'b0;
            end
        endcase

        if (loss) begin
            state_d     = WAIT_LOCK;
            rst_out_d   = '1;
            ready_d     = 1'b0;
            lock_lost_d = 1'b1;
            // A coinciding clear has already zeroed loss_cnt_d, so this yields 1.
            if (loss_cnt_d != '1) begin
                loss_cnt_d = loss_cnt_d + LOSS_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= WAIT_LOCK;
            stable_cnt_q <= '0;
            gap_cnt_q    <= '0;
            idx_q        <= '0;
            rst_out_q    <= '1;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
            loss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            stable_cnt_q <= stable_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            idx_q        <= idx_d;
            rst_out_q    <= rst_out_d;
            ready_q      <= ready_d;
            lock_lost_q  <= lock_lost_d;
            loss_cnt_q   <= loss_cnt_d;
        end
    end

    assign rst_out         = rst_out_q;
    assign ready           = ready_q;
    assign lock_lost       = lock_lost_q;
    assign lock_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed scenarios plus random
// lock/request traffic against a timestamp-based reference model.
module tb_pll_reset_sequencer;

    localparam int SYNC   = 2;
    localparam int STABLE = 8;
    localparam int GAP    = 4;
    localparam int NUM    = 3;
    localparam int LW     = 2;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          pll_locked = 1'b0;
    logic          sw_reset_req = 1'b0;
    logic          clear_status = 1'b0;
    logic [NUM-1:0] rst_out;
    logic          ready;
    logic          lock_lost;
    logic [LW-1:0] lock_loss_count;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pll_reset_sequencer #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .STAGE_GAP    (GAP),
        .NUM_STAGES   (NUM),
        .LOSS_CNT_W   (LW)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .pll_locked     (pll_locked),
        .sw_reset_req   (sw_reset_req),
        .clear_status   (clear_status),
        .rst_out        (rst_out),
        .ready          (ready),
        .lock_lost      (lock_lost),
        .lock_loss_count(lock_loss_count)
    );

    // Reference model: a sequence is "on" from the edge it (re)starts qualifying;
    // every output is a function of how many edges have elapsed since then.
    int        m_n = 0;
    int        m_start = 0;
    bit        m_on = 1'b0;
    bit        m_lost = 1'b0;
    bit [LW-1:0] m_cnt = '0;
    bit        hist[$];
    bit        m_ls;
    bit        m_loss;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_n = 0; m_start = 0; m_on = 1'b0; m_lost = 1'b0; m_cnt = '0;
            hist.delete();
        end else begin
            m_ls   = (hist.size() >= SYNC) ? hist[SYNC-1] : 1'b0;
            m_loss = 1'b0;
            m_n++;
            if (!m_on) begin
                if (m_ls) begin m_on = 1'b1; m_start = m_n; end
            end else if (m_n - 1 - m_start < STABLE) begin
                if (!m_ls) m_on = 1'b0;
            end else if (!m_ls) begin
                m_loss = 1'b1; m_on = 1'b0;
            end else if (sw_reset_req) begin
                m_start = m_n;
            end
            if (clear_status) begin m_lost = 1'b0; m_cnt = '0; end
            if (m_loss) begin
                m_lost = 1'b1;
                if (m_cnt != {LW{1'b1}}) m_cnt = m_cnt + 1'b1;
            end
            hist.push_front(pll_locked);
            if (hist.size() > SYNC) void'(hist.pop_back());
        end
    end

    function automatic logic [NUM+LW+1:0] model_vec();
        logic [NUM-1:0] r;
        logic           rdy;
        for (int k = 0; k < NUM; k++)
            r[k] = !(m_on && m_n >= m_start + STABLE + (k + 1) * GAP);
        rdy = m_on && (m_n >= m_start + STABLE + NUM * GAP);
        return {r, rdy, m_lost, m_cnt};
    endfunction

    task automatic test_reset();
        resetn = 1'b0; pll_locked = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (rst_out !== 3'b111) begin failures++; $display("FAIL reset_rst got=%b exp=111", rst_out); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL reset_lost got=%b exp=0", lock_lost); end
        checks++; if (lock_loss_count !== 2'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", lock_loss_count); end
    endtask

    task automatic test_power_up();
        logic [2:0] exp;
        resetn = 1'b0; pll_locked = 1'b1;
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            exp = (i < 15) ? 3'b111 : (i < 19) ? 3'b110 : (i < 23) ? 3'b100 : 3'b000;
            checks++;
            if (rst_out !== exp || ready !== (i >= 23) || lock_lost !== 1'b0) begin
                failures++;
                $display("FAIL powerup edge=%0d got rst=%b rdy=%b lost=%b exp rst=%b rdy=%b lost=0", i, rst_out, ready, lock_lost, exp, (i >= 23));
            end
            checks++;
            if ({rst_out, ready, lock_lost, lock_loss_count} !== model_vec()) begin
                failures++; $display("FAIL powerup_model edge=%0d got=%b exp=%b", i, {rst_out, ready, lock_lost, lock_loss_count}, model_vec());
            end
        end
    endtask

    task automatic test_glitch();
        resetn = 1'b0; pll_locked = 1'b1;
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 6) pll_locked = 1'b0;
            @(negedge clock);
            checks++;
            if ({rst_out, ready, lock_lost, lock_loss_count} !== model_vec()) begin
                failures++; $display("FAIL glitch_model got=%b exp=%b", {rst_out, ready, lock_lost, lock_loss_count}, model_vec());
            end
        end
        pll_locked = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clock);
            if (i <= 12) begin
                checks++;
                if (rst_out !== 3'b111) begin failures++; $display("FAIL glitch_hold cyc=%0d got=%b exp=111", i, rst_out); end
            end
            checks++;
            if ({rst_out, ready, lock_lost, lock_loss_count} !== model_vec()) begin
                failures++; $display("FAIL glitch_model got=%b exp=%b", {rst_out, ready, lock_lost, lock_loss_count}, model_vec());
            end
        end
        checks++;
        if (ready !== 1'b1 || lock_loss_count !== 2'd0 || lock_lost !== 1'b0) begin
            failures++; $display("FAIL glitch_end got rdy=%b cnt=%0d lost=%b exp rdy=1 cnt=0 lost=0", ready, lock_loss_count, lock_lost);
        end
    endtask

    task automatic test_loss_in_run();
        pll_locked = 1'b0;
        repeat (3) begin
            @(negedge clock);
            checks++;
            if ({rst_out, ready, lock_lost, lock_loss_count} !== model_vec()) begin
                failures++; $display("FAIL loss_model got=%b exp=%b", {rst_out, ready, lock_lost, lock_loss_count}, model_vec());
            end
        end
        checks++;
        if ({rst_out, ready, lock_lost, lock_loss_count} !== 7'b111_0_1_01) begin
            failures++; $display("FAIL loss_state got=%b exp=1110101", {rst_out, ready, lock_lost, lock_loss_count});
        end
        pll_locked = 1'b1;
        repeat (30) begin
            @(negedge clock);
            checks++;
            if ({rst_out, ready, lock_lost, lock_loss_count} !== model_vec()) begin
                failures++; $display("FAIL relock_model got=%b exp=%b", {rst_out, ready, lock_lost, lock_loss_count}, model_vec());
            end
        end
        checks++;
        if (ready !== 1'b1 || rst_out !== 3'b000) begin
            failures++; $display("FAIL relock_ready got rdy=%b rst=%b exp rdy=1 rst=000", ready, rst_out);
        end
    endtask

    task automatic test_saturation_clear();
        clear_status = 1'b1;
        @(negedge clock);
        clear_status = 1'b0;
        checks++;
        if (lock_lost !== 1'b0 || lock_loss_count !== 2'd0 || ready !== 1'b1) begin
            failures++; $display("FAIL clear_alone got lost=%b cnt=%0d rdy=%b exp lost=0 cnt=0 rdy=1", lock_lost, lock_loss_count, ready);
        end
        for (int l = 0; l < 5; l++) begin
            for (int i = 0; i < 32; i++) begin
                pll_locked = (i >= 4);
                @(negedge clock);
                checks++;
                if ({rst_out, ready, lock_lost, lock_loss_count} !== model_vec()) begin
                    failures++; $display("FAIL sat_model loss=%0d got=%b exp=%b", l, {rst_out, ready, lock_lost, lock_loss_count}, model_vec());
                end
            end
        end
        checks++;
        if (lock_loss_count !== 2'd3 || lock_lost !== 1'b1 || ready !== 1'b1) begin
            failures++; $display("FAIL saturate got cnt=%0d lost=%b rdy=%b exp cnt=3 lost=1 rdy=1", lock_loss_count, lock_lost, ready);
        end
        pll_locked = 1'b0;
        repeat (2) @(negedge clock);
        clear_status = 1'b1;
        @(negedge clock);
        clear_status = 1'b0;
        checks++;
        if (lock_loss_count !== 2'd1 || lock_lost !== 1'b1 || rst_out !== 3'b111) begin
            failures++; $display("FAIL clear_vs_loss got cnt=%0d lost=%b rst=%b exp cnt=1 lost=1 rst=111", lock_loss_count, lock_lost, rst_out);
        end
        pll_locked = 1'b1;
        repeat (30) begin
            @(negedge clock);
            checks++;
            if ({rst_out, ready, lock_lost, lock_loss_count} !== model_vec()) begin
                failures++; $display("FAIL clear_relock_model got=%b exp=%b", {rst_out, ready, lock_lost, lock_loss_count}, model_vec());
            end
        end
    endtask

    task automatic test_sw_reset();
        bit found = 1'b0;
        sw_reset_req = 1'b1;
        @(negedge clock);
        sw_reset_req = 1'b0;
        checks++;
        if ({rst_out, ready} !== 4'b1110 || lock_lost !== 1'b1 || lock_loss_count !== 2'd1) begin
            failures++; $display("FAIL sw_assert got rst=%b rdy=%b lost=%b cnt=%0d exp rst=111 rdy=0 lost=1 cnt=1", rst_out, ready, lock_lost, lock_loss_count);
        end
        for (int i = 1; i <= 40 && !found; i++) begin
            @(negedge clock);
            checks++;
            if ({rst_out, ready, lock_lost, lock_loss_count} !== model_vec()) begin
                failures++; $display("FAIL sw_model got=%b exp=%b", {rst_out, ready, lock_lost, lock_loss_count}, model_vec());
            end
            if (rst_out[0] === 1'b0) begin
                found = 1'b1;
                checks++;
                if (i != 12) begin failures++; $display("FAIL sw_release_delay got=%0d exp=12", i); end
            end
        end
        if (!found) begin
            checks++; failures++;
            $display("FAIL sw_release_timeout got=no_release exp=release_after_12");
        end
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        checks++;
        if (rst_out !== 3'b110) begin failures++; $display("FAIL async_pre got=%b exp=110", rst_out); end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({rst_out, ready, lock_lost, lock_loss_count} !== 7'b111_0_0_00) begin
            failures++; $display("FAIL async_reset got=%b exp=1110000", {rst_out, ready, lock_lost, lock_loss_count});
        end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_random();
        int cyc = 0;
        int len;
        while (cyc < 700) begin
            pll_locked = 1'($urandom_range(0, 1));
            len = pll_locked ? int'($urandom_range(3, 40)) : int'($urandom_range(1, 6));
            repeat (len) begin
                sw_reset_req = ($urandom_range(0, 24) == 0);
                clear_status = ($urandom_range(0, 39) == 0);
                @(negedge clock);
                cyc++;
                checks++;
                if ({rst_out, ready, lock_lost, lock_loss_count} !== model_vec()) begin
                    failures++; $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, {rst_out, ready, lock_lost, lock_loss_count}, model_vec());
                end
            end
        end
        sw_reset_req = 1'b0;
        clear_status = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_glitch();
        test_loss_in_run();
        test_saturation_clear();
        test_sw_reset();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
